lab_bist_ctrl: RTL

Self-test sequencer for the team's 3-input combinational lab datapath (inputs a, b, c; outputs x, y). On a start request it drives all 8 input combinations in order and waits a programmable settle time for each. It then samples x/y, compares them against expected truth tables and reports per-vector results plus a pass/fail summary. It sits between the board-level control (button/switch) and the combinational unit, replacing the manual sweep done in simulation.

---
 rtl/lab_bist_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/lab_bist_ctrl.sv
// Self-test sequencer for the 3-input lab datapath: sweeps {a,b,c} through all
// eight vectors, samples x/y after a settle delay and reports per-vector results.
module lab_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXP_X         = 8'h96,
    parameter logic [7:0]  EXP_Y         = 8'hE8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       x,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_count,
    output logic [7:0] mismatch_mask,
    output logic [7:0] result_x,
    output logic [7:0] result_y
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // With no settle time the SETTLE state is bypassed entirely.
    localparam bit         SKIP_SETTLE = (SETTLE_CYCLES == 32'd0);
    localparam logic [3:0] SETTLE_LAST = SKIP_SETTLE ? 4'd0 : 4'(SETTLE_CYCLES - 32'd1);

    function automatic logic vec_mismatch(input logic [2:0] i, input logic xs, input logic ys);
        return (xs != EXP_X[i]) || (ys != EXP_Y[i]);
    endfunction

    state_t     state_r, state_s;
    logic [2:0] idx_r, idx_s;
    logic [3:0] cnt_r, cnt_s;
    logic [2:0] vec_r, vec_s;
    logic [7:0] rx_r, rx_s;
    logic [7:0] ry_r, ry_s;
    logic [7:0] mask_r, mask_s;
    logic [3:0] fc_r, fc_s;
    logic       pass_r, pass_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;

    // Next-state and next-value logic for the sweep sequencer.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        vec_s   = vec_r;
        rx_s    = rx_r;
        ry_s    = ry_r;
        mask_s  = mask_r;
        fc_s    = fc_r;
        pass_s  = pass_r;
        case (state_r)
            ST_IDLE: begin
                vec_s = 3'd0;
                if (start) begin
                    idx_s   = 3'd0;
                    cnt_s   = 4'd0;
                    rx_s    = 8'h00;
                    ry_s    = 8'h00;
                    mask_s  = 8'h00;
                    fc_s    = 4'd0;
                    pass_s  = 1'b0;
                    state_s = SKIP_SETTLE ? ST_SAMPLE : ST_SETTLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                cnt_s = cnt_r + 4'd1;
                if (cnt_r == SETTLE_LAST) begin
                    state_s = ST_SAMPLE;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                rx_s[idx_r] = x;
                ry_s[idx_r] = y;
                if (vec_mismatch(idx_r, x, y)) begin
                    mask_s[idx_r] = 1'b1;
                    fc_s = (fc_r < 4'd8) ? fc_r + 4'd1 : fc_r;
                end else begin
                    fc_s = fc_r;
                end
                if (idx_r == 3'd7) begin
                    state_s = ST_DONE;
                end else begin
                    idx_s   = idx_r + 3'd1;
                    vec_s   = idx_r + 3'd1;
                    cnt_s   = 4'd0;
                    state_s = SKIP_SETTLE ? ST_SAMPLE : ST_SETTLE;
                end
            end
            ST_DONE: begin
                // fc_r already includes vector 7, captured on the way into DONE.
                pass_s  = (fc_r == 4'd0);
                vec_s   = 3'd0;
                state_s = ST_IDLE;
            end
            default: begin
                vec_s   = 3'd0;
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            idx_r   <= 3'd0;
            cnt_r   <= 4'd0;
            vec_r   <= 3'd0;
            rx_r    <= 8'h00;
            ry_r    <= 8'h00;
            mask_r  <= 8'h00;
            fc_r    <= 4'd0;
            pass_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            vec_r   <= vec_s;
            rx_r    <= rx_s;
            ry_r    <= ry_s;
            mask_r  <= mask_s;
            fc_r    <= fc_s;
            pass_r  <= pass_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign a             = vec_r[2];
    assign b             = vec_r[1];
    assign c             = vec_r[0];
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign fail_count    = fc_r;
    assign mismatch_mask = mask_r;
    assign result_x      = rx_r;
    assign result_y      = ry_r;

endmodule
